// File: rtl/basilisk_vector_issue_sequencer.sv
// Breaks one vector FP command into UNIT_WIDTH-lane beats carrying a beat offset and lane mask.
// Beats start the cycle after acceptance; outputs hold under backpressure; a new command can chain on the last beat.
module basilisk_vector_issue_sequencer #(
  parameter int VECTOR_WIDTH = 16,
  parameter int UNIT_WIDTH   = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int LENGTH_WIDTH = 5,
  parameter int OP_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4:0]              cmd_dest_reg_addr,
  input  logic [LENGTH_WIDTH-1:0] cmd_vector_length,
  input  logic [OP_WIDTH-1:0]     cmd_op,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [4:0]              beat_dest_reg_addr,
  output logic [OFFSET_WIDTH-1:0] beat_dest_offset_addr,
  output logic [UNIT_WIDTH-1:0]   beat_lane_mask,
  output logic [OP_WIDTH-1:0]     beat_op,
  output logic                    beat_last,
  output logic                    done,
  output logic                    busy
);

  localparam int BW = LENGTH_WIDTH + 1;

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  state_t                  state;
  logic [LENGTH_WIDTH-1:0] len_r;
  logic [LENGTH_WIDTH-1:0] len_c;
  logic                    hs;
  logic                    hs_last;
  logic                    accept;
  logic [OFFSET_WIDTH-1:0] k_next;

  // Base lane index is formed one bit wider than the length so it cannot wrap.
  function automatic logic [UNIT_WIDTH-1:0] mask_for(input logic [OFFSET_WIDTH-1:0] k,
                                                     input logic [LENGTH_WIDTH-1:0] len);
    logic [BW-1:0] base;
    logic [UNIT_WIDTH-1:0] m;
    base = BW'(k) * BW'(UNIT_WIDTH);
    m = '0;
    for (int i = 0; i < UNIT_WIDTH; i++) begin
      m[i] = (base + BW'(i)) < {1'b0, len};
    end
    return m;
  endfunction

  function automatic logic last_for(input logic [OFFSET_WIDTH-1:0] k,
                                    input logic [LENGTH_WIDTH-1:0] len);
    logic [BW-1:0] base;
    base = BW'(k) * BW'(UNIT_WIDTH);
    return (base + BW'(UNIT_WIDTH)) >= {1'b0, len};
  endfunction

  assign len_c     = (cmd_vector_length > LENGTH_WIDTH'(VECTOR_WIDTH)) ?
                     LENGTH_WIDTH'(VECTOR_WIDTH) : cmd_vector_length;
  assign hs        = beat_valid & beat_ready;
  assign hs_last   = hs & beat_last;
  assign cmd_ready = ((state == IDLE) | hs_last) & ~flush;
  assign accept    = cmd_valid & cmd_ready;
  assign k_next    = beat_dest_offset_addr + OFFSET_WIDTH'(1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      len_r                 <= '0;
      beat_valid            <= 1'b0;
      beat_dest_reg_addr    <= '0;
      beat_dest_offset_addr <= '0;
      beat_lane_mask        <= '0;
      beat_op               <= '0;
      beat_last             <= 1'b0;
      done                  <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      beat_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ISSUE && hs && !beat_last) begin
        beat_dest_offset_addr <= k_next;
        beat_lane_mask        <= mask_for(k_next, len_r);
        beat_last             <= last_for(k_next, len_r);
      end else if ((state == IDLE) || hs_last) begin
        // A last-beat handshake completes the current command; an accepted command may start at once.
        if (hs_last) done <= 1'b1;
        if (accept && len_c != '0) begin
          state                 <= ISSUE;
          len_r                 <= len_c;
          beat_valid            <= 1'b1;
          beat_dest_reg_addr    <= cmd_dest_reg_addr;
          beat_op               <= cmd_op;
          beat_dest_offset_addr <= '0;
          beat_lane_mask        <= mask_for('0, len_c);
          beat_last             <= last_for('0, len_c);
        end else begin
          if (accept) done <= 1'b1;
          state      <= IDLE;
          beat_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_basilisk_vector_issue_sequencer.sv
// Directed bench for basilisk_vector_issue_sequencer with hand-computed beat offsets, masks and done timing.
module tb_basilisk_vector_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_dest_reg_addr;
  logic [4:0] cmd_vector_length;
  logic [2:0] cmd_op;
  logic       beat_valid;
  logic       beat_ready;
  logic [4:0] beat_dest_reg_addr;
  logic [1:0] beat_dest_offset_addr;
  logic [3:0] beat_lane_mask;
  logic [2:0] beat_op;
  logic       beat_last;
  logic       done;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  basilisk_vector_issue_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush                 (flush),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_dest_reg_addr     (cmd_dest_reg_addr),
    .cmd_vector_length     (cmd_vector_length),
    .cmd_op                (cmd_op),
    .beat_valid            (beat_valid),
    .beat_ready            (beat_ready),
    .beat_dest_reg_addr    (beat_dest_reg_addr),
    .beat_dest_offset_addr (beat_dest_offset_addr),
    .beat_lane_mask        (beat_lane_mask),
    .beat_op               (beat_op),
    .beat_last             (beat_last),
    .done                  (done),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] len, input logic [4:0] dst, input logic [2:0] op);
    cmd_valid         = 1'b1;
    cmd_vector_length = len;
    cmd_dest_reg_addr = dst;
    cmd_op            = op;
    #1;
    chk("cmd_ready_at_send", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Walks nb beats with beat_ready high, then expects a single done pulse.
  task automatic check_beats(input logic [4:0] dst, input logic [2:0] op, input int nb,
                             input logic [3:0] last_mask);
    for (int k = 0; k < nb; k++) begin
      chk("beat_valid", 32'(beat_valid), 32'd1);
      chk("offset", 32'(beat_dest_offset_addr), 32'(k));
      chk("mask", 32'(beat_lane_mask), (k == nb - 1) ? 32'(last_mask) : 32'hF);
      chk("last", 32'(beat_last), (k == nb - 1) ? 32'd1 : 32'd0);
      chk("done_mid", 32'(done), 32'd0);
      chk("dest", 32'(beat_dest_reg_addr), 32'(dst));
      chk("op", 32'(beat_op), 32'(op));
      cyc();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_after", 32'(beat_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    cyc();
    chk("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; beat_ready = 1'b1;
    cmd_dest_reg_addr = '0; cmd_vector_length = '0; cmd_op = '0;
    #2;
    chk("rst_valid", 32'(beat_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(beat_lane_mask), 32'd0);
    chk("rst_offset", 32'(beat_dest_offset_addr), 32'd0);
    chk("rst_dest", 32'(beat_dest_reg_addr), 32'd0);
    chk("rst_last", 32'(beat_last), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full vector, partial last beat, clamped oversize length.
    send(5'd16, 5'h0A, 3'd3);
    check_beats(5'h0A, 3'd3, 4, 4'hF);
    send(5'd6, 5'h11, 3'd5);
    check_beats(5'h11, 3'd5, 2, 4'h3);
    send(5'd20, 5'h1F, 3'd7);
    check_beats(5'h1F, 3'd7, 4, 4'hF);
    send(5'd31, 5'h02, 3'd1);
    check_beats(5'h02, 3'd1, 4, 4'hF);
    send(5'd1, 5'h03, 3'd2);
    check_beats(5'h03, 3'd2, 1, 4'h1);

    // Zero length: accepted, no beats, done the next cycle.
    send(5'd0, 5'h04, 3'd0);
    chk("zl_valid", 32'(beat_valid), 32'd0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd0);
    cyc();
    chk("zl_done_once", 32'(done), 32'd0);
    chk("zl_valid2", 32'(beat_valid), 32'd0);

    // Backpressure on beat 1 of len=8.
    send(5'd8, 5'h05, 3'd4);
    chk("st_off0", 32'(beat_dest_offset_addr), 32'd0);
    cyc();
    beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_valid", 32'(beat_valid), 32'd1);
      chk("st_off", 32'(beat_dest_offset_addr), 32'd1);
      chk("st_mask", 32'(beat_lane_mask), 32'hF);
      chk("st_last", 32'(beat_last), 32'd1);
      chk("st_done", 32'(done), 32'd0);
    end
    beat_ready = 1'b1;
    cyc();
    chk("st_done_rel", 32'(done), 32'd1);
    chk("st_valid_rel", 32'(beat_valid), 32'd0);
    cyc();

    // Chaining A(len 4) into B(len 5) with no idle cycle.
    send(5'd4, 5'h06, 3'd1);
    chk("ch_a_valid", 32'(beat_valid), 32'd1);
    chk("ch_a_last", 32'(beat_last), 32'd1);
    chk("ch_a_mask", 32'(beat_lane_mask), 32'hF);
    send(5'd5, 5'h07, 3'd6);
    chk("ch_a_done", 32'(done), 32'd1);
    chk("ch_b_valid", 32'(beat_valid), 32'd1);
    chk("ch_b_dest", 32'(beat_dest_reg_addr), 32'h07);
    chk("ch_b_op", 32'(beat_op), 32'd6);
    chk("ch_b0_off", 32'(beat_dest_offset_addr), 32'd0);
    chk("ch_b0_mask", 32'(beat_lane_mask), 32'hF);
    chk("ch_b0_last", 32'(beat_last), 32'd0);
    cyc();
    chk("ch_b1_off", 32'(beat_dest_offset_addr), 32'd1);
    chk("ch_b1_mask", 32'(beat_lane_mask), 32'h1);
    chk("ch_b1_last", 32'(beat_last), 32'd1);
    chk("ch_b1_done", 32'(done), 32'd0);
    cyc();
    chk("ch_b_done", 32'(done), 32'd1);
    chk("ch_b_end", 32'(beat_valid), 32'd0);
    cyc();

    // Flush during beat 2 of len=16; a command offered under flush is refused.
    send(5'd16, 5'h08, 3'd2);
    cyc();
    cyc();
    chk("fl_off2", 32'(beat_dest_offset_addr), 32'd2);
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_vector_length = 5'd4;
    #1;
    chk("fl_cmd_ready", 32'(cmd_ready), 32'd0);
    cyc();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("fl_valid", 32'(beat_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_done", 32'(done), 32'd0);
    cyc();
    chk("fl_done2", 32'(done), 32'd0);
    chk("fl_valid2", 32'(beat_valid), 32'd0);

    // Async reset in the middle of a command.
    send(5'd16, 5'h09, 3'd5);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(beat_valid), 32'd0);
    chk("ar_offset", 32'(beat_dest_offset_addr), 32'd0);
    chk("ar_mask", 32'(beat_lane_mask), 32'd0);
    chk("ar_dest", 32'(beat_dest_reg_addr), 32'd0);
    chk("ar_op", 32'(beat_op), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_valid2", 32'(beat_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
